// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a shared external decoder and frame-aligned word commit.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking of the upper digits.
module seg_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  load,
  input  logic [6:0]            seg_in,
  output logic [3:0]            bcd_out,
  output logic [6:0]            seg_out,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_sync
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } phase_e;

  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] active_q, active_d;
  logic [4*N_DIGITS-1:0] pending_q, pending_d;
  logic                  pend_q, pend_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_sync_q, frame_sync_d;

  phase_e     phase;
  logic [3:0] nibble;
  logic       invalid;
  logic       hide;
  logic       slot_end;
  logic       frame_end;
`ifdef SEG_SCAN_LZB_EN
  logic       suppress;
`endif

  // Slot decode: the current digit, whether it may be shown, and which anode (if any) is pulled low.
  always_comb begin
    nibble = 4'h0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) nibble = active_q[4*k +: 4];
    end
    invalid = (nibble > 4'd9);
`ifdef SEG_SCAN_LZB_EN
    suppress = 1'b0;
    for (int k = 1; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) suppress = ((active_q >> (4*k)) == '0);
    end
    hide = invalid | suppress;
`else
    hide = invalid;
`endif
    phase   = (div_cnt_q < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
    bcd_out = invalid ? 4'h0 : nibble;
    for (int k = 0; k < N_DIGITS; k++) begin
      an_n[k] = !((phase == ST_DRIVE) && !hide && (idx_q == IDX_W'(k)));
    end
  end

  // A load on the commit cycle still lands in pending, so it waits for the following frame end.
  always_comb begin
    slot_end     = (div_cnt_q == CNT_LAST);
    frame_end    = slot_end && (idx_q == IDX_LAST);
    div_cnt_d    = slot_end ? '0 : div_cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    active_d     = active_q;
    pending_d    = pending_q;
    pend_d       = pend_q;
    frame_sync_d = 1'b0;
    seg_d        = hide ? 7'b0 : seg_in;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    if (frame_end && pend_q) begin
      active_d     = pending_q;
      pend_d       = 1'b0;
      frame_sync_d = 1'b1;
    end
    if (load) begin
      pending_d = digits_in;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
      seg_q        <= 7'b0;
      frame_sync_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      seg_q        <= seg_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign seg_out    = seg_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2) with a behavioural decoder on seg_in.
// Expectations follow SEG_SCAN_LZB_EN so the same bench covers both builds.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] SEG0 = 7'b1111110;
  localparam logic [6:0] SEG1 = 7'b0110000;
  localparam logic [6:0] SEG2 = 7'b1101101;
  localparam logic [6:0] SEG4 = 7'b0110011;
  localparam logic [6:0] SEG5 = 7'b1011011;
  localparam logic [6:0] SEG6 = 7'b1011111;
  localparam logic [6:0] SEG7 = 7'b1110000;

  logic          clk;
  logic          rst_n;
  logic [15:0]   digits_in;
  logic          load;
  logic [6:0]    seg_in;
  logic [3:0]    bcd_out;
  logic [6:0]    seg_out;
  logic [ND-1:0] an_n;
  logic          frame_sync;

  int testCount;
  int failCount;
  int cyc;
  int syncCount;
  int syncBase;

  seg_scan_ctrl #(
    .N_DIGITS    (ND),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .load      (load),
    .seg_in    (seg_in),
    .bcd_out   (bcd_out),
    .seg_out   (seg_out),
    .an_n      (an_n),
    .frame_sync(frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder (abcdefg, a = MSB); codes above 9 return junk so forced blanking is visible.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0: decode = 7'b1111110;
      4'd1: decode = 7'b0110000;
      4'd2: decode = 7'b1101101;
      4'd3: decode = 7'b1111001;
      4'd4: decode = 7'b0110011;
      4'd5: decode = 7'b1011011;
      4'd6: decode = 7'b1011111;
      4'd7: decode = 7'b1110000;
      4'd8: decode = 7'b1111111;
      4'd9: decode = 7'b1111011;
      default: decode = 7'b1010101;
    endcase
  endfunction

  assign seg_in = decode(bcd_out);

  function automatic logic [3:0] anFor(input int k);
    logic [3:0] one;
    one = 4'b0001;
    anFor = ~(one << k);
  endfunction

  always @(posedge clk) begin
    if (frame_sync) syncCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cyc %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic gotoCyc(input int target);
    while (cyc < target) stepCycle();
  endtask

  task automatic applyStimulus(input logic [15:0] word);
    digits_in = word;
    load      = 1'b1;
    stepCycle();
    load      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testCount = 0;
    failCount = 0;
    syncCount = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = 16'h0000;

    // Reset state, then a reset asserted in the middle of a DRIVE phase.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_an", 32'(an_n), 32'hF);
    checkOutput("rst_seg", 32'(seg_out), 32'h0);
    checkOutput("rst_fs", 32'(frame_sync), 32'h0);
    checkOutput("rst_bcd", 32'(bcd_out), 32'h0);
    rst_n = 1'b1;
    cyc   = 0;
    gotoCyc(4);
    checkOutput("pre_rst_an", 32'(an_n), 32'(anFor(0)));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_an", 32'(an_n), 32'hF);
    checkOutput("mid_rst_seg", 32'(seg_out), 32'h0);
    checkOutput("mid_rst_fs", 32'(frame_sync), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    stepCycle();
    checkOutput("blank_an", 32'(an_n), 32'hF);
    gotoCyc(2);
    checkOutput("drive_an", 32'(an_n), 32'(anFor(0)));
    checkOutput("drive_seg", 32'(seg_out), 32'(SEG0));

    // Load mid-frame: the old word stays on display until the frame end.
    gotoCyc(11);
    applyStimulus(16'h1234);
    gotoCyc(13);
    checkOutput("hold_an", 32'(an_n), LZB ? 32'hF : 32'(anFor(1)));
    checkOutput("hold_seg", 32'(seg_out), LZB ? 32'h0 : 32'(SEG0));
    gotoCyc(20);
    checkOutput("hold_bcd", 32'(bcd_out), 32'h0);
    gotoCyc(31);
    checkOutput("fs_before", 32'(frame_sync), 32'h0);
    stepCycle();
    checkOutput("fs_pulse", 32'(frame_sync), 32'h1);
    stepCycle();
    checkOutput("fs_after", 32'(frame_sync), 32'h0);
    gotoCyc(34);
    checkOutput("w1234_s0_an", 32'(an_n), 32'(anFor(0)));
    checkOutput("w1234_s0_seg", 32'(seg_out), 32'(SEG4));
    checkOutput("w1234_s0_bcd", 32'(bcd_out), 32'h4);
    gotoCyc(60);
    checkOutput("w1234_s3_an", 32'(an_n), 32'(anFor(3)));
    checkOutput("w1234_s3_seg", 32'(seg_out), 32'(SEG1));
    checkOutput("w1234_s3_bcd", 32'(bcd_out), 32'h1);

    // Two loads in one frame: latest wins, a single frame_sync.
    gotoCyc(40);
    syncBase = syncCount;
    applyStimulus(16'h1111);
    gotoCyc(45);
    applyStimulus(16'h2222);
    for (int k = 0; k < 4; k++) begin
      gotoCyc(64 + 8*k + 4);
      checkOutput("w2222_an", 32'(an_n), 32'(anFor(k)));
      checkOutput("w2222_seg", 32'(seg_out), 32'(SEG2));
    end
    gotoCyc(96);
    checkOutput("w2222_syncs", 32'(syncCount - syncBase), 32'd1);

    // Invalid nibble in digit 2 blanks that slot entirely.
    applyStimulus(16'h0A00);
    gotoCyc(132);
    checkOutput("w0A00_s0_an", 32'(an_n), 32'(anFor(0)));
    checkOutput("w0A00_s0_seg", 32'(seg_out), 32'(SEG0));
    gotoCyc(140);
    checkOutput("w0A00_s1_an", 32'(an_n), 32'(anFor(1)));
    checkOutput("w0A00_s1_seg", 32'(seg_out), 32'(SEG0));
    for (int d = 2; d < 8; d++) begin
      gotoCyc(144 + d);
      checkOutput("bad_an", 32'(an_n), 32'hF);
      checkOutput("bad_seg", 32'(seg_out), 32'h0);
      checkOutput("bad_bcd", 32'(bcd_out), 32'h0);
    end
    gotoCyc(156);
    checkOutput("w0A00_s3_an", 32'(an_n), LZB ? 32'hF : 32'(anFor(3)));
    checkOutput("w0A00_s3_seg", 32'(seg_out), LZB ? 32'h0 : 32'(SEG0));

    // Load on the frame-end cycle: old pending commits now, new word one frame later.
    applyStimulus(16'h5555);
    gotoCyc(159);
    checkOutput("fe_fs_before", 32'(frame_sync), 32'h0);
    digits_in = 16'h6666;
    load      = 1'b1;
    stepCycle();
    load      = 1'b0;
    checkOutput("fe_fs_first", 32'(frame_sync), 32'h1);
    stepCycle();
    checkOutput("fe_fs_drop", 32'(frame_sync), 32'h0);
    gotoCyc(164);
    checkOutput("w5555_seg", 32'(seg_out), 32'(SEG5));
    checkOutput("w5555_bcd", 32'(bcd_out), 32'h5);
    gotoCyc(191);
    checkOutput("fe_fs_gap", 32'(frame_sync), 32'h0);
    stepCycle();
    checkOutput("fe_fs_second", 32'(frame_sync), 32'h1);
    gotoCyc(196);
    checkOutput("w6666_seg", 32'(seg_out), 32'(SEG6));
    checkOutput("w6666_bcd", 32'(bcd_out), 32'h6);

    // Leading zeros: only digit 0 is driven when blanking is enabled.
    gotoCyc(200);
    applyStimulus(16'h0007);
    gotoCyc(228);
    checkOutput("w0007_s0_an", 32'(an_n), 32'(anFor(0)));
    checkOutput("w0007_s0_seg", 32'(seg_out), 32'(SEG7));
    checkOutput("w0007_s0_bcd", 32'(bcd_out), 32'h7);
    for (int k = 1; k < 4; k++) begin
      gotoCyc(224 + 8*k + 4);
      checkOutput("lz_an", 32'(an_n), LZB ? 32'hF : 32'(anFor(k)));
      checkOutput("lz_seg", 32'(seg_out), LZB ? 32'h0 : 32'(SEG0));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
